// File: rtl/traffic_phase_controller.sv
// Two-direction intersection sequencer. Paces an external saturating count-down
// timer and handles emergency pre-emption; lamps decode from state only.
module traffic_phase_controller #(
    parameter int BIT_WIDTH   = 7,
    parameter int GREEN_TIME  = 20,
    parameter int YELLOW_TIME = 4,
    parameter int ALLRED_TIME = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 emg_req,
    input  logic                 timer_zero,
    output logic                 timer_down,
    output logic                 timer_emg_load,
    output logic [BIT_WIDTH-1:0] timer_load_val,
    output logic [2:0]           ns_light,
    output logic [2:0]           ew_light
);

    typedef enum logic [2:0] {
        SYNC     = 3'd0,
        NS_G     = 3'd1,
        NS_Y     = 3'd2,
        RED_A    = 3'd3,
        EW_G     = 3'd4,
        EW_Y     = 3'd5,
        RED_B    = 3'd6,
        EMG_HOLD = 3'd7
    } state_t;

    localparam logic [BIT_WIDTH-1:0] GREEN_VAL  = BIT_WIDTH'(GREEN_TIME);
    localparam logic [BIT_WIDTH-1:0] YELLOW_VAL = BIT_WIDTH'(YELLOW_TIME);
    localparam logic [BIT_WIDTH-1:0] ALLRED_VAL = BIT_WIDTH'(ALLRED_TIME);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t state;
    state_t next_state;
    state_t succ;
    logic   emg_q;
    logic   emg_pend;
    logic   emg_any;
    logic   advance;

    // Pending is dropped whenever the hold is (or stays) the next state, so a
    // request that is still high inside the hold does not trigger a second hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SYNC;
            emg_q    <= 1'b0;
            emg_pend <= 1'b0;
        end else begin
            state <= next_state;
            emg_q <= emg_req;
            if (next_state == EMG_HOLD) begin
                emg_pend <= 1'b0;
            end else if (emg_q) begin
                emg_pend <= 1'b1;
            end
        end
    end

    // succ is the state entered when the current phase ends; the reload value
    // is always the duration of succ so the timer is primed on the same edge.
    always_comb begin
        succ           = state;
        advance        = timer_zero;
        timer_down     = 1'b1;
        timer_emg_load = 1'b0;
        emg_any        = emg_q | emg_pend;
        case (state)
            SYNC: begin
                succ           = RED_B;
                advance        = 1'b1;
                timer_down     = 1'b0;
                timer_emg_load = 1'b1;
            end
            NS_G: begin
                succ = NS_Y;
                if (emg_q) begin
                    advance        = 1'b1;
                    timer_emg_load = 1'b1;
                end
            end
            NS_Y:  succ = emg_any ? EMG_HOLD : RED_A;
            RED_A: succ = emg_any ? EMG_HOLD : EW_G;
            EW_G: begin
                succ = EW_Y;
                if (emg_q) begin
                    advance        = 1'b1;
                    timer_emg_load = 1'b1;
                end
            end
            EW_Y:  succ = emg_any ? EMG_HOLD : RED_B;
            RED_B: succ = emg_any ? EMG_HOLD : NS_G;
            EMG_HOLD: begin
                if (emg_q) begin
                    succ       = EMG_HOLD;
                    advance    = 1'b0;
                    timer_down = 1'b0;
                end else begin
                    succ = NS_G;
                end
            end
            default: begin
                succ    = SYNC;
                advance = 1'b1;
            end
        endcase

        next_state = advance ? succ : state;

        case (succ)
            NS_G, EW_G: timer_load_val = GREEN_VAL;
            NS_Y, EW_Y: timer_load_val = YELLOW_VAL;
            default:    timer_load_val = ALLRED_VAL;
        endcase
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state)
            NS_G:    ns_light = LAMP_GREEN;
            NS_Y:    ns_light = LAMP_YELLOW;
            EW_G:    ew_light = LAMP_GREEN;
            EW_Y:    ew_light = LAMP_YELLOW;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

endmodule
